// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES core arbiter: controller states, default
// datapath width and requester index constants.
package aes_ctrl_pkg;

  localparam int unsigned DATA_W_DEFAULT = 128;

  // Requester indices: bit positions in req_valid/req_ready/rsp_valid/rsp_ready
  localparam int unsigned REQ_HOST = 0;
  localparam int unsigned REQ_PUF  = 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins outright; on a tie the
// requester that was not granted last time wins. last_grant lives in the parent.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant selection
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two requesters. Grants round-robin, latches the
// winner's plaintext/key, pulses core_start, waits for core_done under a
// watchdog and returns the ciphertext (or a timeout error) on a valid/ready
// response to the granted requester.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned CNT_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req0_key,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req1_key,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [DATA_W-1:0] core_key,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_result,
  output logic              busy
);

  state_t           state, state_next;
  logic [1:0]       arb_grant;
  logic             grant_idx;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  rr_arbiter2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant)
  );

  // The watchdog fires on the TIMEOUT-th WAIT cycle, so RESP appears
  // TIMEOUT+1 cycles after LAUNCH.
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake/control outputs
  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by reset so a requester never sees an accept that reset discards
        if (!reset) req_ready = arb_grant;
        if (arb_grant != 2'b00) state_next = LAUNCH;
      end
      LAUNCH: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (core_done || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid[grant_idx] = 1'b1;
        if (rsp_ready[grant_idx]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job datapath: operand latch, grant bookkeeping, watchdog and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      core_data  <= '0;
      core_key   <= '0;
      grant_idx  <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_grant != 2'b00) begin
            grant_idx  <= arb_grant[REQ_PUF];
            last_grant <= arb_grant[REQ_PUF];
            core_data  <= arb_grant[REQ_PUF] ? req1_data : req0_data;
            core_key   <= arb_grant[REQ_PUF] ? req1_key  : req0_key;
          end
        end
        LAUNCH: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc;
          if (core_done) begin
            rsp_data <= core_result;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/aes_core_arbiter.md
Name: aes_core_arbiter

Overview:
- Shares one AES_circuit instance between two requesters, e.g. the host/VIO path and the PUF key-generator self-test path.
- Arbitrates round-robin and latches the granted plaintext and key.
- Launches the core with a one-cycle start pulse, waits for the core's `sure` done flag under a watchdog, then returns the ciphertext to the granted requester through a valid/ready response.
- Sits between the requesters and AES_circuit at the top level.

Parameters:
- DATA_W, 128, width of plaintext, key and ciphertext.
- TIMEOUT, 63, maximum WAIT cycles before the job is aborted with an error; must be ≥ 1.
- CNT_W, 6, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester job request (bit0 = requester 0)
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_data  in  DATA_W  requester 0 plaintext
- req0_key  in  DATA_W  requester 0 key
- req1_data  in  DATA_W  requester 1 plaintext
- req1_key  in  DATA_W  requester 1 key
- rsp_valid  out  2  per-requester result valid; one-hot or zero
- rsp_ready  in  2  per-requester result accept
- rsp_data  out  DATA_W  ciphertext, shared by both requesters
- rsp_err  out  1  qualifies rsp_valid: 1 = watchdog timeout, rsp_data = 0
- core_start  out  1  one-cycle launch pulse to AES_circuit
- core_data  out  DATA_W  plaintext to core, held stable from LAUNCH through WAIT
- core_key  out  DATA_W  key to core, held stable from LAUNCH through WAIT
- core_done  in  1  core `sure` flag
- core_result  in  DATA_W  core data_out
- busy  out  1  high in every state except IDLE

Behaviour:
- Single clock. Reset is synchronous and active-high; it is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - state = IDLE
  - all outputs 0
  - core_data/core_key registers = 0
  - last_grant = 1, so requester 0 wins the first tie
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - No req_valid bit set: stay in IDLE.
  - Exactly one bit set: grant that requester.
  - Both bits set: grant the requester that is not last_grant.
  - req_ready is combinational, asserted for the granted index only while in IDLE. The handshake completes in that same cycle.
  - On grant: latch data/key into core_data/core_key, record grant index, update last_grant, go to LAUNCH.
- LAUNCH: core_start = 1 for exactly this cycle, counter cleared, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - core_done = 1: register core_result into rsp_data, rsp_err = 0, go to RESP.
  - Counter reaches TIMEOUT and core_done = 0: rsp_data = 0, rsp_err = 1, go to RESP.
  - core_done and timeout in the same cycle: core_done wins.
  - Minimum request-accept-to-rsp_valid latency is 3 cycles (LAUNCH, WAIT, then RESP visible).
- RESP:
  - rsp_valid[grant] held high, and rsp_data/rsp_err held stable, until rsp_ready[grant] = 1.
  - On that handshake: rsp_valid drops next cycle, return to IDLE. No new grant occurs in the handshake cycle.
  - rsp_ready on the non-granted bit is ignored.
- core_done while in IDLE, LAUNCH or RESP is ignored.
- req_valid arriving during a job: held off (req_ready = 0), no loss. Requesters must hold data/key stable until req_ready.
- Reset mid-job: abandon the job immediately, no response issued; core_start is not reasserted until a new grant.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

Decomposition:
- Shared package aes_ctrl_pkg:
  - state enum (IDLE/LAUNCH/WAIT/RESP)
  - DATA_W default
  - requester index constants REQ_HOST = 0, REQ_PUF = 1
- One natural sub-module, rr_arbiter2: 2-way round-robin grant logic (req[1:0], last_grant → grant one-hot), purely combinational, with last_grant kept in the parent.

Test Plan:
- Single job, requester 0: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, real AES_circuit attached → rsp_valid = 01, rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err = 0, core_start high exactly one cycle.
- Both requesters valid from reset, 4 jobs each, rsp_ready tied high → grant order 0,1,0,1,… and each rsp_valid carries the matching requester's ciphertext.
- Core model that never asserts core_done, TIMEOUT = 63 → rsp_valid 64 cycles after LAUNCH with rsp_err = 1, rsp_data = 0; next job then completes normally.
- Response backpressure: rsp_ready held 0 for 20 cycles → rsp_valid and rsp_data stable, req_ready stays 0 for a pending request, and it is granted only after the handshake.
- Reset asserted for one cycle mid-WAIT → next cycle: all outputs 0, busy = 0; a late core_done is ignored; next request is served with requester 0 priority.
- core_done pulse injected in IDLE and in RESP → no state change, rsp_data unchanged.
